// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets two requesters share one combinational ALU.
// One operation is in flight at a time: accept, execute (1 cycle), respond.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [OPW-1:0]   alu_control,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  input  logic [WIDTH-1:0] alu_ans,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic [OPW-1:0]   op_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             owner_reg;
  logic             last_grant_reg;
  logic [1:0]       rsp_valid_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic             rsp_zero_reg;

  logic             grant;
  logic             accept;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Sole valid requester wins; on contention the one not served last time wins.
  always_comb begin
    grant = ~req_valid[0];
    if (req_valid == 2'b11)
      grant = ~last_grant_reg;
  end

  assign accept = (state_reg == IDLE) && req_valid[grant];

  // Ready is masked by rst_n so it reads 0 for the whole reset assertion.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = rst_n && (state_reg == IDLE) &&
                             (grant == 1'(gi)) && req_valid[gi];
    end
  endgenerate

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      rsp_valid_reg  <= 2'b00;
      rsp_data_reg   <= '0;
      rsp_zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg         <= sel_op;
            a_reg          <= sel_a;
            b_reg          <= sel_b;
            owner_reg      <= grant;
            last_grant_reg <= grant;
          end
        end
        EXEC: begin
          rsp_data_reg  <= alu_ans;
          rsp_zero_reg  <= alu_zero;
          rsp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
        end
        RESP: begin
          if (rsp_ready[owner_reg])
            rsp_valid_reg <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  // The ALU only ever sees the latched operands, never the request ports.
  assign alu_control = op_reg;
  assign alu_src1    = a_reg;
  assign alu_src2    = b_reg;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU on the ALU side, directed
// scenarios, then randomized traffic against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [OPW-1:0]   req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic [OPW-1:0]   alu_control;
  logic [WIDTH-1:0] alu_src1, alu_src2;
  logic [WIDTH-1:0] alu_ans;
  logic             alu_zero;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_ans(alu_ans), .alu_zero(alu_zero), .busy(busy)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return 32'($signed(a) >>> b[4:0]);
      4'd8: return {31'd0, ($signed(a) < $signed(b))};
      4'd9: return {31'd0, (a < b)};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic zero_fn(input logic [3:0] op, input logic [31:0] ans);
    return (op <= 4'd9) && (ans == 32'd0);
  endfunction

  always_comb begin
    alu_ans  = alu_fn(alu_control, alu_src1, alu_src2);
    alu_zero = zero_fn(alu_control, alu_ans);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    req_valid = 2'b11;
    #3;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_checks++; if (rsp_data !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_checks++; if (rsp_zero !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_zero: got %b want 0", rsp_zero); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (alu_control !== 4'd0) begin n_fail++; $display("FAIL reset_alu_control: got %h want 0", alu_control); end
    n_checks++; if (alu_src1 !== 32'd0) begin n_fail++; $display("FAIL reset_alu_src1: got %h want 0", alu_src1); end
    n_checks++; if (alu_src2 !== 32'd0) begin n_fail++; $display("FAIL reset_alu_src2: got %h want 0", alu_src2); end
    #9;
    req_valid = 2'b00;
    rst_n = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    req_valid = 2'b01; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7; rsp_ready = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_exec_busy: got %b want 1", busy); end
    n_checks++; if (alu_src1 !== 32'd5 || alu_src2 !== 32'd7 || alu_control !== 4'd0) begin
      n_fail++; $display("FAIL single_alu_drive: got %h/%h/%h want 0/5/7", alu_control, alu_src1, alu_src2); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_exec_rsp_valid: got %b want 00", rsp_valid); end
    step();
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
    n_checks++; if (rsp_data !== 32'd12) begin n_fail++; $display("FAIL single_rsp_data: got %h want 0000000c", rsp_data); end
    n_checks++; if (rsp_zero !== 1'b0) begin n_fail++; $display("FAIL single_rsp_zero: got %b want 0", rsp_zero); end
    step();
    n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_back_idle: got rsp_valid=%b busy=%b want 00/0", rsp_valid, busy); end
  endtask

  task automatic test_contention_from_reset();
    reset_dut();
    req0_op = 4'd1; req0_a = 32'd9;    req0_b = 32'd9;
    req1_op = 4'd4; req1_a = 32'hF0;   req1_b = 32'h0F;
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL contend_first_grant: got %b want 01", req_ready); end
    step();
    req_valid = 2'b10;
    step();
    n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd0 || rsp_zero !== 1'b1) begin
      n_fail++; $display("FAIL contend_req0_rsp: got v=%b d=%h z=%b want 01/0/1", rsp_valid, rsp_data, rsp_zero); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL contend_blocked: got %b want 00", req_ready); end
    step();
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL contend_second_grant: got %b want 10", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    n_checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'hFF || rsp_zero !== 1'b0) begin
      n_fail++; $display("FAIL contend_req1_rsp: got v=%b d=%h z=%b want 10/ff/0", rsp_valid, rsp_data, rsp_zero); end
    step();
  endtask

  task automatic test_alternate();
    logic [31:0] exp_d;
    logic        exp_z;
    logic [1:0]  exp_oh;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      req0_op = 4'($urandom_range(0, 9)); req0_a = $urandom; req0_b = $urandom;
      req1_op = 4'($urandom_range(0, 9)); req1_a = $urandom; req1_b = $urandom;
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_d  = (k % 2 == 0) ? alu_fn(req0_op, req0_a, req0_b) : alu_fn(req1_op, req1_a, req1_b);
      exp_z  = (exp_d == 32'd0);
      #1;
      n_checks++; if (req_ready !== exp_oh) begin n_fail++; $display("FAIL alt_grant_%0d: got %b want %b", k, req_ready, exp_oh); end
      step();
      step();
      n_checks++; if (rsp_valid !== exp_oh || rsp_data !== exp_d || rsp_zero !== exp_z) begin
        n_fail++; $display("FAIL alt_rsp_%0d: got v=%b d=%h z=%b want %b/%h/%b", k, rsp_valid, rsp_data, rsp_zero, exp_oh, exp_d, exp_z); end
      step();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_stall();
    req_valid = 2'b10; req1_op = 4'd7; req1_a = 32'h8000_0000; req1_b = 32'd4; rsp_ready = 2'b00;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL stall_grant: got %b want 10", req_ready); end
    step();
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'hF800_0000 || rsp_zero !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold_%0d: got v=%b d=%h z=%b want 10/f8000000/0", i, rsp_valid, rsp_data, rsp_zero); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_ready_%0d: got %b want 00", i, req_ready); end
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    step();
    n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got v=%b busy=%b want 00/0", rsp_valid, busy); end
  endtask

  task automatic test_reset_in_exec();
    req_valid = 2'b01; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1; rsp_ready = 2'b11;
    step();
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      n_fail++; $display("FAIL rstexec_ctrl: got busy=%b v=%b rdy=%b want 0/00/00", busy, rsp_valid, req_ready); end
    n_checks++; if (alu_control !== 4'd0 || alu_src1 !== 32'd0 || alu_src2 !== 32'd0 || rsp_data !== 32'd0 || rsp_zero !== 1'b0) begin
      n_fail++; $display("FAIL rstexec_data: got c=%h s1=%h s2=%h d=%h z=%b want all 0", alu_control, alu_src1, alu_src2, rsp_data, rsp_zero); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rstexec_dropped_%0d: got v=%b busy=%b want 00/0", i, rsp_valid, busy); end
    end
    req_valid = 2'b01; req0_op = 4'd9; req0_a = 32'd1; req0_b = 32'd2;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstexec_next_grant: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd1) begin
      n_fail++; $display("FAIL rstexec_next_rsp: got v=%b d=%h want 01/1", rsp_valid, rsp_data); end
    step();
  endtask

  task automatic test_illegal_op();
    req_valid = 2'b01; req0_op = 4'hC; req0_a = 32'd3; req0_b = 32'd4; rsp_ready = 2'b11;
    step();
    req_valid = 2'b00;
    n_checks++; if (alu_control !== 4'hC) begin n_fail++; $display("FAIL illegal_passthru: got %h want c", alu_control); end
    step();
    n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd0 || rsp_zero !== 1'b0) begin
      n_fail++; $display("FAIL illegal_rsp: got v=%b d=%h z=%b want 01/0/0", rsp_valid, rsp_data, rsp_zero); end
    step();
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL illegal_done: got busy=%b v=%b want 0/00", busy, rsp_valid); end
  endtask

  // Model: an op is outstanding from accept until its response handshake;
  // its response is visible from the second edge after accept onward.
  task automatic test_random();
    bit          pend [2];
    logic [3:0]  p_op [2];
    logic [31:0] p_a [2];
    logic [31:0] p_b [2];
    bit          outstanding = 0, visible = 0, done, acc;
    int          owner = 0, last = 1, g = 0, txn = 0;
    logic [31:0] exp_d = 0;
    logic        exp_z = 0;
    logic [1:0]  exp_rdy, exp_rv;
    reset_dut();
    pend[0] = 0; pend[1] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          p_op[i] = 4'($urandom_range(0, 15));
          p_a[i]  = $urandom;
          p_b[i]  = ($urandom_range(0, 3) == 0) ? p_a[i] : $urandom;
        end
      end
      req_valid = {pend[1], pend[0]};
      req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
      req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
      rsp_ready = 2'($urandom_range(0, 3));
      #1;
      exp_rdy = 2'b00;
      if (!outstanding && (pend[0] || pend[1])) begin
        g = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
        exp_rdy[g] = 1'b1;
      end
      exp_rv = visible ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready_c%0d: got %b want %b", cyc, req_ready, exp_rdy); end
      n_checks++; if (busy !== outstanding) begin n_fail++; $display("FAIL rand_busy_c%0d: got %b want %b", cyc, busy, outstanding); end
      n_checks++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rand_rsp_valid_c%0d: got %b want %b", cyc, rsp_valid, exp_rv); end
      if (visible) begin
        n_checks++; if (rsp_data !== exp_d || rsp_zero !== exp_z) begin
          n_fail++; $display("FAIL rand_rsp_data_c%0d: got d=%h z=%b want %h/%b", cyc, rsp_data, rsp_zero, exp_d, exp_z); end
      end
      done = visible && rsp_ready[owner];
      if (done) begin
        txn++;
        $display("txn %0d: req%0d data=%h zero=%b", txn, owner, exp_d, exp_z);
      end
      acc = (exp_rdy != 2'b00);
      step();
      if (outstanding && visible && done) begin
        outstanding = 0; visible = 0;
      end else if (outstanding && !visible) begin
        visible = 1;
      end
      if (acc) begin
        outstanding = 1; visible = 0;
        owner = g; last = g;
        exp_d = alu_fn(p_op[g], p_a[g], p_b[g]);
        exp_z = zero_fn(p_op[g], exp_d);
        pend[g] = 0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention_from_reset();
    test_alternate();
    test_stall();
    test_reset_in_exec();
    test_illegal_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
